// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 frame receiver.
//   - receiver FSM state encoding
//   - frame length derivation (start + data + parity + stop)
//   - default parameter values (100 MHz system clock)
package ps2_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    // 34 us at 100 MHz: longest allowed gap between two bit edges of a frame.
    localparam int DEF_TIMEOUT_CYC = 3400;

    // Minimum safe synchroniser depth for asynchronous pins.
    localparam int DEF_SYNC_STAGES = 2;

    // Start bit, payload, parity bit and stop bit.
    function automatic int frame_len(input int data_bits);
        return data_bits + 3;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: multi-flop synchroniser with falling-edge detection for one
// asynchronous input line. All flops reset to 1 because PS/2 lines idle high,
// so leaving reset never produces a spurious falling edge.
//
// Ports:
//   ck    in   system clock
//   reset in   asynchronous active-low reset
//   din   in   raw asynchronous line
//   dout  out  synchronised line (last synchroniser stage)
//   fall  out  high for one cycle when dout goes 1 -> 0
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic ck,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: receives one PS/2-style frame per transfer
// (start, DATA_BITS data LSB first, parity, stop), validates it and presents
// the payload through a valid/ready output register.
//
// Ports:
//   ck          in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   ps2_clk     in   raw device clock (async, idles high)
//   ps2_data    in   raw device data (async, idles high)
//   rx_data     out  received payload, stable while rx_valid=1
//   rx_valid    out  payload available
//   rx_ready    in   consumer accepts when rx_valid & rx_ready
//   parity_err  out  1-cycle pulse, frame dropped on parity mismatch
//   frame_err   out  1-cycle pulse, bad start/stop bit, frame dropped
//   timeout_err out  1-cycle pulse, frame aborted after inter-bit timeout
//   overrun     out  1-cycle pulse, good frame dropped (previous unaccepted)
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter bit PARITY_ODD  = 1'b1,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 timeout_err,
    output logic                 overrun
);

    localparam int FRAME_LEN = frame_len(DATA_BITS);
    localparam int TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int BC_W      = $clog2(FRAME_LEN + 1);

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
    // Timeout fires in the cycle the counter would step onto TO_MAX.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    // bitcnt value just before the stop bit arrives.
    localparam logic [BC_W-1:0] BC_PENULT = BC_W'(FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic clk_fall;
    logic clk_sync_unused;
    logic data_s;
    logic data_fall_unused;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .ck    (ck),
        .reset (reset),
        .din   (ps2_clk),
        .dout  (clk_sync_unused),
        .fall  (clk_fall)
    );

    // Data line only needs synchronising; it is sampled on the clock-line edge.
    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .ck    (ck),
        .reset (reset),
        .din   (ps2_data),
        .dout  (data_s),
        .fall  (data_fall_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ps2_state_e             state_q,       state_d;
    logic [BC_W-1:0]        bitcnt_q,      bitcnt_d;
    logic [TO_W-1:0]        tcnt_q,        tcnt_d;
    logic [FRAME_LEN-1:0]   shift_q,       shift_d;
    logic [DATA_BITS-1:0]   rx_data_q,     rx_data_d;
    logic                   rx_valid_q,    rx_valid_d;
    logic                   parity_err_q,  parity_err_d;
    logic                   frame_err_q,   frame_err_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   overrun_q,     overrun_d;

    // Fields of a completed frame; bits enter at the MSB and shift right.
    logic                 f_start;
    logic                 f_stop;
    logic                 f_parity;
    logic [DATA_BITS-1:0] f_payload;

    always_comb begin
        f_start   = shift_q[0];
        f_stop    = shift_q[FRAME_LEN-1];
        f_parity  = shift_q[FRAME_LEN-2];
        f_payload = shift_q[DATA_BITS:1];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        tcnt_d        = '0;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;

        // Handshake: payload consumed, valid drops next cycle. A load in
        // CHECK below overrides this, keeping valid high for the new word.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A falling edge with data high is line noise, not a start bit.
                if (clk_fall && !data_s) begin
                    shift_d  = {data_s, shift_q[FRAME_LEN-1:1]};
                    bitcnt_d = BC_W'(1);
                    state_d  = RECV;
                end
            end

            RECV: begin
                if (clk_fall) begin
                    shift_d  = {data_s, shift_q[FRAME_LEN-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BC_PENULT) begin
                        state_d = CHECK;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    bitcnt_d      = '0;
                    state_d       = IDLE;
                end else begin
                    tcnt_d = (tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + 1'b1;
                end
            end

            CHECK: begin
                bitcnt_d = '0;
                state_d  = IDLE;
                if (f_start || !f_stop) begin
                    frame_err_d = 1'b1;
                end else if ((^{f_payload, f_parity}) != PARITY_ODD) begin
                    parity_err_d = 1'b1;
                end else if (rx_valid_q && !rx_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    rx_data_d  = f_payload;
                    rx_valid_d = 1'b1;
                end
            end

            default: begin
                bitcnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bitcnt_q      <= '0;
            tcnt_q        <= '0;
            // NOTE: the shift register is a plain flop vector, so it is reset
            // like any other state; a partial frame must not survive reset.
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            tcnt_q        <= tcnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed and randomized frames against ps2_frame_rx.
// Expected results come from a frame-level model (parity by bit counting,
// a pending-word flag for valid/ready) and from timing derived from the
// synchroniser depth.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int DATA_BITS   = 8;
    localparam int TIMEOUT_CYC = 3400;
    localparam bit PARITY_ODD  = 1'b1;
    localparam int SYNC_STAGES = 2;
    localparam int FL          = DATA_BITS + 3;
    localparam int HALF        = 30;

    logic                 ck       = 1'b0;
    logic                 reset    = 1'b0;
    logic                 ps2_clk  = 1'b1;
    logic                 ps2_data = 1'b1;
    logic                 rx_ready = 1'b0;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 timeout_err;
    logic                 overrun;

    ps2_frame_rx #(
        .DATA_BITS   (DATA_BITS),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PARITY_ODD  (PARITY_ODD),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .ck          (ck),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 ck = ~ck;

    // Cycle stamp, advanced on every rising edge.
    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    // Output monitor: counts high cycles of each pulse and valid rises.
    int   n_par = 0, n_frm = 0, n_to = 0, n_ovr = 0, n_vrise = 0, n_vhi = 0;
    int   to_cyc = 0, vrise_cyc = 0;
    logic v_prev = 1'b0;
    always @(negedge ck) begin
        if (parity_err) n_par++;
        if (frame_err)  n_frm++;
        if (overrun)    n_ovr++;
        if (timeout_err) begin
            n_to++;
            to_cyc = cyc;
        end
        if (rx_valid) n_vhi++;
        if (rx_valid && !v_prev) begin
            n_vrise++;
            vrise_cyc = cyc;
        end
        v_prev = rx_valid;
    end

    int checks = 0;
    int errors = 0;
    int s_par, s_frm, s_to, s_ovr, s_vrise, s_vhi;
    int drop_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_par   = n_par;
        s_frm   = n_frm;
        s_to    = n_to;
        s_ovr   = n_ovr;
        s_vrise = n_vrise;
        s_vhi   = n_vhi;
    endtask

    task automatic check_pulses(input string tag, input int e_par, input int e_frm,
                                input int e_to, input int e_ovr, input int e_vrise);
        check({tag, "_parity_err"},  n_par - s_par,     e_par);
        check({tag, "_frame_err"},   n_frm - s_frm,     e_frm);
        check({tag, "_timeout_err"}, n_to - s_to,       e_to);
        check({tag, "_overrun"},     n_ovr - s_ovr,     e_ovr);
        check({tag, "_valid_rises"}, n_vrise - s_vrise, e_vrise);
    endtask

    // Sends the first n bits of a frame; ps2_clk is left low after the last.
    task automatic send_bits(input logic [FL-1:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (half) @(negedge ck);
            ps2_clk  = 1'b0;
            drop_cyc = cyc;
            if (i != n - 1) begin
                repeat (half) @(negedge ck);
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic release_clk(input int half);
        repeat (half) @(negedge ck);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (half) @(negedge ck);
    endtask

    // Parity bit that makes (ones in data + parity) odd for PARITY_ODD=1.
    function automatic logic good_parity(input logic [DATA_BITS-1:0] d);
        int ones;
        ones = $countones(d);
        return PARITY_ODD ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic logic [FL-1:0] mk_frame(input logic [DATA_BITS-1:0] d,
                                               input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_good(input logic [DATA_BITS-1:0] d);
        send_bits(mk_frame(d, good_parity(d), 1'b1), FL, HALF);
        release_clk(HALF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [DATA_BITS-1:0] r_data;
    int                   r_mode, r_half, lat;
    logic                 r_ready, r_par, r_stop;
    logic                 m_valid, e_load, e_ovr;
    logic [DATA_BITS-1:0] m_data;

    initial begin
        // ---------------- reset state
        repeat (3) @(negedge ck);
        check("reset_rx_data",  rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_pulses",   {parity_err, frame_err, timeout_err, overrun}, 0);
        reset = 1'b1;
        repeat (4) @(negedge ck);

        // ---------------- good frame 0xA5, ready high
        rx_ready = 1'b1;
        snap();
        send_bits(mk_frame(8'hA5, 1'b1, 1'b1), FL, HALF);
        repeat (10) @(negedge ck);
        check("good_latency", vrise_cyc - drop_cyc, SYNC_STAGES + 2);
        check("good_valid_cycles", n_vhi - s_vhi, 1);
        check("good_rx_data", rx_data, 8'hA5);
        release_clk(HALF);
        check_pulses("good", 0, 0, 0, 0, 1);

        // ---------------- parity error: 0xA5 with parity 0
        snap();
        send_bits(mk_frame(8'hA5, 1'b0, 1'b1), FL, HALF);
        release_clk(HALF);
        check_pulses("par", 1, 0, 0, 0, 0);
        check("par_rx_data",  rx_data, 8'hA5);
        check("par_rx_valid", rx_valid, 0);

        // ---------------- frame error: 0x3C with stop 0
        snap();
        send_bits(mk_frame(8'h3C, good_parity(8'h3C), 1'b0), FL, HALF);
        release_clk(HALF);
        check_pulses("frm", 0, 1, 0, 0, 0);
        check("frm_rx_data", rx_data, 8'hA5);

        // ---------------- timeout: start + 5 data bits, then silence
        snap();
        send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 6, HALF);
        release_clk(HALF);
        repeat (TIMEOUT_CYC + 100) @(negedge ck);
        check_pulses("to", 0, 0, 1, 0, 0);
        lat = to_cyc - drop_cyc;
        check("to_latency_window",
              (lat >= TIMEOUT_CYC + SYNC_STAGES) && (lat <= TIMEOUT_CYC + SYNC_STAGES + 2), 1);
        rx_ready = 1'b0;
        snap();
        send_good(8'h3C);
        check_pulses("after_to", 0, 0, 0, 0, 1);
        check("after_to_rx_data", rx_data, 8'h3C);
        rx_ready = 1'b1;
        @(negedge ck);
        rx_ready = 1'b0;
        @(negedge ck);
        check("after_to_valid_cleared", rx_valid, 0);

        // ---------------- overrun: 0x11 then 0x22 with ready low
        snap();
        send_good(8'h11);
        check("ovr_first_valid", rx_valid, 1);
        check("ovr_first_data",  rx_data, 8'h11);
        send_good(8'h22);
        check_pulses("ovr", 0, 0, 0, 1, 1);
        check("ovr_kept_data",  rx_data, 8'h11);
        check("ovr_kept_valid", rx_valid, 1);

        // ---------------- accept in the same CHECK cycle as a new load
        snap();
        send_bits(mk_frame(8'h22, good_parity(8'h22), 1'b1), FL, HALF);
        repeat (SYNC_STAGES + 1) @(negedge ck);
        rx_ready = 1'b1;
        @(negedge ck);
        rx_ready = 1'b0;
        check("simul_valid", rx_valid, 1);
        check("simul_data",  rx_data, 8'h22);
        release_clk(HALF);
        check_pulses("simul", 0, 0, 0, 0, 0);
        check("simul_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge ck);
        rx_ready = 1'b0;
        check("simul_valid_cleared", rx_valid, 0);

        // ---------------- reset in the middle of a frame
        send_good(8'h5A);
        check("rst_pre_valid", rx_valid, 1);
        send_bits(mk_frame(8'h55, good_parity(8'h55), 1'b1), 4, HALF);
        repeat (5) @(negedge ck);
        reset = 1'b0;
        #1;
        check("rst_async_outputs",
              {rx_valid, rx_data, parity_err, frame_err, timeout_err, overrun}, 0);
        @(negedge ck);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge ck);
        reset = 1'b1;
        repeat (4) @(negedge ck);
        rx_ready = 1'b1;
        snap();
        send_good(8'h55);
        check_pulses("rst_after", 0, 0, 0, 0, 1);
        check("rst_after_data", rx_data, 8'h55);

        // ---------------- randomized frames against the frame-level model
        m_data  = 8'h55;
        m_valid = 1'b0;
        for (int k = 0; k < 24; k++) begin
            r_data   = DATA_BITS'($urandom);
            r_mode   = $urandom_range(0, 3);  // 0,1 good; 2 bad parity; 3 bad stop
            r_half   = $urandom_range(8, 40);
            r_ready  = 1'b1 & $urandom_range(0, 1);
            rx_ready = r_ready;
            if (r_ready) m_valid = 1'b0;      // pending word accepted at once
            r_par  = good_parity(r_data) ^ (r_mode == 2);
            r_stop = (r_mode != 3);
            e_ovr  = (r_mode < 2) && m_valid;
            e_load = (r_mode < 2) && !m_valid;
            snap();
            send_bits(mk_frame(r_data, r_par, r_stop), FL, r_half);
            release_clk(r_half);
            if (e_load) begin
                m_data  = r_data;
                m_valid = !r_ready;
            end
            check_pulses("rand", int'(r_mode == 2), int'(r_mode == 3), 0,
                         int'(e_ovr), int'(e_load));
            check("rand_rx_data",  rx_data, m_data);
            check("rand_rx_valid", rx_valid, m_valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
